// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake and an optional 2-entry skid buffer.
// Flush clears only the control bundle unless CLR_DATA is set; out_ctrl is zero whenever out_valid is low.
module pipe_stage_skid #(
    parameter int N        = 24,
    parameter int NLANES   = 3,
    parameter int CW       = 20,
    parameter int TW       = 12,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         in_ctrl,
    input  logic [NLANES*N-1:0]   in_data,
    input  logic [TW-1:0]         in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         out_ctrl,
    output logic [NLANES*N-1:0]   out_data,
    output logic [TW-1:0]         out_tag,
    output logic [1:0]            occupancy
);

    localparam int DW       = NLANES * N;
    localparam bit HAS_SKID = (SKID != 32'sd0);
    localparam bit CLR_DAT  = (CLR_DATA != 32'sd0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic            valid_r, valid_s;
    logic            rdy_r, rdy_s;
    logic [1:0]      occ_r, occ_s;
    logic            beat_in_s, beat_out_s;

    logic [CW-1:0]   main_ctrl_r, main_ctrl_s;
    logic [DW-1:0]   main_data_r, main_data_s;
    logic [TW-1:0]   main_tag_r, main_tag_s;
    logic [CW-1:0]   skid_ctrl_r, skid_ctrl_s;
    logic [DW-1:0]   skid_data_r, skid_data_s;
    logic [TW-1:0]   skid_tag_r, skid_tag_s;

    // With a skid entry in_ready is a flop; without one it must look through to out_ready.
    assign in_ready   = HAS_SKID ? rdy_r : (~valid_r | out_ready);
    assign beat_in_s  = in_valid & in_ready;
    assign beat_out_s = valid_r & out_ready;

    assign out_valid  = valid_r;
    assign out_ctrl   = main_ctrl_r;
    assign out_data   = main_data_r;
    assign out_tag    = main_tag_r;
    assign occupancy  = occ_r;

    // Next-state and entry update; flush overrides every handshake.
    always_comb begin
        state_s     = state_r;
        main_ctrl_s = main_ctrl_r;
        main_data_s = main_data_r;
        main_tag_s  = main_tag_r;
        skid_ctrl_s = skid_ctrl_r;
        skid_data_s = skid_data_r;
        skid_tag_s  = skid_tag_r;

        if (flush) begin
            state_s     = ST_EMPTY;
            main_ctrl_s = '0;
            skid_ctrl_s = '0;
            if (CLR_DAT) begin
                main_data_s = '0;
                main_tag_s  = '0;
                skid_data_s = '0;
                skid_tag_s  = '0;
            end else begin
                main_data_s = main_data_r;
                skid_data_s = skid_data_r;
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (beat_in_s) begin
                        state_s     = ST_ONE;
                        main_ctrl_s = in_ctrl;
                        main_data_s = in_data;
                        main_tag_s  = in_tag;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (beat_in_s && beat_out_s) begin
                        main_ctrl_s = in_ctrl;
                        main_data_s = in_data;
                        main_tag_s  = in_tag;
                    end else if (beat_in_s) begin
                        if (HAS_SKID) begin
                            state_s     = ST_FULL;
                            skid_ctrl_s = in_ctrl;
                            skid_data_s = in_data;
                            skid_tag_s  = in_tag;
                        end else begin
                            // Unreachable without skid: accept implies downstream took the head.
                            main_ctrl_s = in_ctrl;
                            main_data_s = in_data;
                            main_tag_s  = in_tag;
                        end
                    end else if (beat_out_s) begin
                        state_s     = ST_EMPTY;
                        main_ctrl_s = '0;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (beat_out_s) begin
                        state_s     = ST_ONE;
                        main_ctrl_s = skid_ctrl_r;
                        main_data_s = skid_data_r;
                        main_tag_s  = skid_tag_r;
                        skid_ctrl_s = '0;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s     = ST_EMPTY;
                    main_ctrl_s = '0;
                    skid_ctrl_s = '0;
                end
            endcase
        end
    end

    // Status flags decoded from the next state so they are registered alongside it.
    always_comb begin
        valid_s = 1'b0;
        rdy_s   = 1'b1;
        occ_s   = 2'd0;
        case (state_s)
            ST_EMPTY: begin
                valid_s = 1'b0;
                rdy_s   = 1'b1;
                occ_s   = 2'd0;
            end
            ST_ONE: begin
                valid_s = 1'b1;
                rdy_s   = 1'b1;
                occ_s   = 2'd1;
            end
            ST_FULL: begin
                valid_s = 1'b1;
                rdy_s   = 1'b0;
                occ_s   = 2'd2;
            end
            default: begin
                valid_s = 1'b0;
                rdy_s   = 1'b1;
                occ_s   = 2'd0;
            end
        endcase
    end

    // State, status and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            rdy_r       <= 1'b1;
            occ_r       <= 2'd0;
            main_ctrl_r <= '0;
            main_data_r <= '0;
            main_tag_r  <= '0;
            skid_ctrl_r <= '0;
            skid_data_r <= '0;
            skid_tag_r  <= '0;
        end else begin
            state_r     <= state_s;
            valid_r     <= valid_s;
            rdy_r       <= rdy_s;
            occ_r       <= occ_s;
            main_ctrl_r <= main_ctrl_s;
            main_data_r <= main_data_s;
            main_tag_r  <= main_tag_s;
            skid_ctrl_r <= skid_ctrl_s;
            skid_data_r <= skid_data_s;
            skid_tag_r  <= skid_tag_s;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid/no-clear, skid/clear-on-flush and no-skid builds share one stimulus.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [19:0] in_ctrl;
    logic [71:0] in_data;
    logic [11:0] in_tag;

    logic        d1_in_ready, d1_out_valid;
    logic [19:0] d1_out_ctrl;
    logic [71:0] d1_out_data;
    logic [11:0] d1_out_tag;
    logic [1:0]  d1_occ;

    logic        d2_in_ready, d2_out_valid;
    logic [19:0] d2_out_ctrl;
    logic [71:0] d2_out_data;
    logic [11:0] d2_out_tag;
    logic [1:0]  d2_occ;

    logic        d0_in_ready, d0_out_valid;
    logic [19:0] d0_out_ctrl;
    logic [71:0] d0_out_data;
    logic [11:0] d0_out_tag;
    logic [1:0]  d0_occ;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(.SKID(1), .CLR_DATA(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .out_valid(d1_out_valid), .out_ready(out_ready),
        .out_ctrl(d1_out_ctrl), .out_data(d1_out_data), .out_tag(d1_out_tag),
        .occupancy(d1_occ)
    );

    pipe_stage_skid #(.SKID(1), .CLR_DATA(1)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_ctrl(d2_out_ctrl), .out_data(d2_out_data), .out_tag(d2_out_tag),
        .occupancy(d2_occ)
    );

    pipe_stage_skid #(.SKID(0), .CLR_DATA(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .out_valid(d0_out_valid), .out_ready(out_ready),
        .out_ctrl(d0_out_ctrl), .out_data(d0_out_data), .out_tag(d0_out_tag),
        .occupancy(d0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [19:0] c, input logic [23:0] d0, input logic [11:0] t);
        in_valid = v;
        in_ctrl  = c;
        in_data  = {48'h0, d0};
        in_tag   = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        step();
        check_eq("rst_valid", {63'd0, d1_out_valid}, 64'd0);
        check_eq("rst_ctrl",  {44'd0, d1_out_ctrl}, 64'd0);
        check_eq("rst_occ",   {62'd0, d1_occ}, 64'd0);
        check_eq("rst_ready", {63'd0, d1_in_ready}, 64'd1);
        step();
        rst = 1'b0;

        // 1: streaming with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 20'h00001, 24'h000101, 12'h001);
        step();
        check_eq("s1_valid", {63'd0, d1_out_valid}, 64'd1);
        check_eq("s1_ctrl1", {44'd0, d1_out_ctrl}, 64'h1);
        check_eq("s1_occ1",  {62'd0, d1_occ}, 64'd1);
        drive(1'b1, 20'h00002, 24'h000202, 12'h002);
        step();
        check_eq("s1_ctrl2", {44'd0, d1_out_ctrl}, 64'h2);
        check_eq("s1_occ2",  {62'd0, d1_occ}, 64'd1);
        drive(1'b1, 20'h00003, 24'h000303, 12'h003);
        step();
        check_eq("s1_ctrl3", {44'd0, d1_out_ctrl}, 64'h3);
        check_eq("s1_data3", {40'd0, d1_out_data[23:0]}, 64'h000303);
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        step();
        check_eq("s1_bubble_v", {63'd0, d1_out_valid}, 64'd0);
        check_eq("s1_bubble_c", {44'd0, d1_out_ctrl}, 64'd0);
        check_eq("s1_occ0",     {62'd0, d1_occ}, 64'd0);

        // 2: stall into skid, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 20'h00011, 24'hAAAAAA, 12'h0A1);
        step();
        check_eq("s2_occA", {62'd0, d1_occ}, 64'd1);
        drive(1'b1, 20'h00022, 24'hBBBBBB, 12'h0B2);
        step();
        check_eq("s2_occ2",  {62'd0, d1_occ}, 64'd2);
        check_eq("s2_rdy0",  {63'd0, d1_in_ready}, 64'd0);
        check_eq("s2_headA", {40'd0, d1_out_data[23:0]}, 64'hAAAAAA);
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        step();
        check_eq("s2_holdA", {40'd0, d1_out_data[23:0]}, 64'hAAAAAA);
        check_eq("s2_holdc", {44'd0, d1_out_ctrl}, 64'h11);
        check_eq("s2_hold2", {62'd0, d1_occ}, 64'd2);
        out_ready = 1'b1;
        step();
        check_eq("s2_headB", {40'd0, d1_out_data[23:0]}, 64'hBBBBBB);
        check_eq("s2_ctrlB", {44'd0, d1_out_ctrl}, 64'h22);
        check_eq("s2_tagB",  {52'd0, d1_out_tag}, 64'h0B2);
        check_eq("s2_rdy1",  {63'd0, d1_in_ready}, 64'd1);
        check_eq("s2_occ1",  {62'd0, d1_occ}, 64'd1);
        step();
        check_eq("s2_empty", {63'd0, d1_out_valid}, 64'd0);

        // 3/4: flush while FULL with a beat presented
        out_ready = 1'b0;
        drive(1'b1, 20'h00033, 24'h123456, 12'h123);
        step();
        drive(1'b1, 20'h00044, 24'h654321, 12'h321);
        step();
        check_eq("s3_full", {62'd0, d1_occ}, 64'd2);
        flush = 1'b1;
        drive(1'b1, 20'h00055, 24'hCCCCCC, 12'hCCC);
        step();
        check_eq("s3_valid", {63'd0, d1_out_valid}, 64'd0);
        check_eq("s3_ctrl",  {44'd0, d1_out_ctrl}, 64'd0);
        check_eq("s3_occ",   {62'd0, d1_occ}, 64'd0);
        check_eq("s3_rdy",   {63'd0, d1_in_ready}, 64'd1);
        check_eq("s4_hold_data", {40'd0, d1_out_data[23:0]}, 64'h123456);
        check_eq("s4_hold_tag",  {52'd0, d1_out_tag}, 64'h123);
        check_eq("s4_clr_data",  {40'd0, d2_out_data[23:0]}, 64'd0);
        check_eq("s4_clr_tag",   {52'd0, d2_out_tag}, 64'd0);
        check_eq("s4_clr_ctrl",  {44'd0, d2_out_ctrl}, 64'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        step();
        check_eq("s3_noC_a", {63'd0, d1_out_valid}, 64'd0);
        step();
        check_eq("s3_noC_b", {63'd0, d1_out_valid}, 64'd0);

        // flush while ONE discards an accepted beat
        out_ready = 1'b0;
        drive(1'b1, 20'h00077, 24'hDDDDDD, 12'h0DD);
        step();
        check_eq("s3b_occ1", {62'd0, d1_occ}, 64'd1);
        flush = 1'b1;
        drive(1'b1, 20'h00088, 24'hEEEEEE, 12'h0EE);
        step();
        check_eq("s3b_occ0",  {62'd0, d1_occ}, 64'd0);
        check_eq("s3b_ctrl0", {44'd0, d1_out_ctrl}, 64'd0);
        check_eq("s3b_dataD", {40'd0, d1_out_data[23:0]}, 64'hDDDDDD);
        flush = 1'b0;
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        step();
        check_eq("s3b_noE", {63'd0, d1_out_valid}, 64'd0);
        check_eq("s3b_rdy", {63'd0, d1_in_ready}, 64'd1);

        // 5: async reset mid-cycle while FULL
        out_ready = 1'b0;
        drive(1'b1, 20'h00091, 24'h111111, 12'h111);
        step();
        drive(1'b1, 20'h00092, 24'h222222, 12'h222);
        step();
        check_eq("s5_full", {62'd0, d1_occ}, 64'd2);
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("s5_valid", {63'd0, d1_out_valid}, 64'd0);
        check_eq("s5_occ",   {62'd0, d1_occ}, 64'd0);
        check_eq("s5_ctrl",  {44'd0, d1_out_ctrl}, 64'd0);
        check_eq("s5_data",  {40'd0, d1_out_data[23:0]}, 64'd0);
        check_eq("s5_tag",   {52'd0, d1_out_tag}, 64'd0);
        rst = 1'b0;
        step();
        check_eq("s5_rdy",    {63'd0, d1_in_ready}, 64'd1);
        check_eq("s5_valid2", {63'd0, d1_out_valid}, 64'd0);

        // 6: no-skid build, combinational in_ready and pass-through
        out_ready = 1'b0;
        drive(1'b1, 20'h00066, 24'h0F0F0F, 12'h066);
        #1;
        check_eq("s6_rdy_empty", {63'd0, d0_in_ready}, 64'd1);
        step();
        check_eq("s6_valid", {63'd0, d0_out_valid}, 64'd1);
        check_eq("s6_ctrl",  {44'd0, d0_out_ctrl}, 64'h66);
        check_eq("s6_rdy0",  {63'd0, d0_in_ready}, 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 20'h00071, 24'h070701, 12'h071);
        #1;
        check_eq("s6_rdy_comb", {63'd0, d0_in_ready}, 64'd1);
        step();
        check_eq("s6_p1", {44'd0, d0_out_ctrl}, 64'h71);
        drive(1'b1, 20'h00072, 24'h070702, 12'h072);
        step();
        check_eq("s6_p2", {44'd0, d0_out_ctrl}, 64'h72);
        check_eq("s6_occ", {62'd0, d0_occ}, 64'd1);
        drive(1'b1, 20'h00073, 24'h070703, 12'h073);
        step();
        check_eq("s6_p3",   {44'd0, d0_out_ctrl}, 64'h73);
        check_eq("s6_d3",   {40'd0, d0_out_data[23:0]}, 64'h070703);
        drive(1'b0, 20'h0, 24'h0, 12'h0);
        step();
        check_eq("s6_drain", {63'd0, d0_out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
